// File: rtl/sdram_cache_pkg.sv
// sdram_cache_pkg: shared types for the SDRAM line cache.
// FSM states, line type and word selection helper.
package sdram_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    GAP
  } state_e;

  localparam int LINE_WORDS = 4;

  typedef logic [63:0] line_t;

  // Pick one 16-bit word out of a 4-word line.
  function automatic logic [15:0] word_sel(
    input line_t      l,
    input logic [1:0] off
  );
    return l[16*off +: 16];
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: valid/tag/data arrays of the line cache.
// One combinational read port, one fill write port, flush clear.
module cache_line_store
  import sdram_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IW    = 4,
  parameter int TW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [TW-1:0] wtag_i,
  input  line_t         wdata_i,
  input  logic [IW-1:0] ridx_i,
  output logic          rvalid_o,
  output logic [TW-1:0] rtag_o,
  output line_t         rdata_o
);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  line_t            data_q [LINES];

  // Valid flops: whole vector cleared on flush, one bit set per fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/sdram_line_cache.sv
// sdram_line_cache: read-only direct-mapped cache, one SDRAM burst channel.
// Optional hit/miss counters with SDRAM_LINE_CACHE_STATS_EN.
module sdram_line_cache
  import sdram_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int AW    = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [AW:1]   rd_addr,
  input  logic          rd_req,
  output logic [15:0]   rd_data,
  output logic          rd_ack,
  output logic [AW:1]   sdr_addr,
  output logic          sdr_req,
  input  logic [63:0]   sdr_dout,
  input  logic          sdr_ready
`ifdef SDRAM_LINE_CACHE_STATS_EN
  ,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AW - 2 - IW;
  localparam int OW = $clog2(LINE_WORDS);

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;

  assign off = rd_addr[OW:1];
  assign idx = rd_addr[2+IW:3];
  assign tag = rd_addr[AW:3+IW];

  state_e        state_q;
  logic [15:0]   rd_data_q;
  logic          rd_ack_q;
  logic [AW:1]   sdr_addr_q;
  logic          sdr_req_q;
  logic          pend_q;
  logic [OW-1:0] off_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tag_q;

  logic          st_valid;
  logic [TW-1:0] st_tag;
  line_t         st_data;
  logic          hit;
  logic          hit_go;
  logic          miss_go;
  logic          fill_done;
  logic          install;

  assign hit = st_valid && (st_tag == tag);
  assign hit_go = (state_q == IDLE) && !flush && rd_req && hit;
  assign miss_go = (state_q == IDLE) && !flush && rd_req && !hit;
  assign fill_done = (state_q == FILL) && sdr_ready;
  assign install = fill_done && !pend_q && !flush;

  cache_line_store #(
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (flush),
    .we_i     (install),
    .widx_i   (idx_q),
    .wtag_i   (tag_q),
    .wdata_i  (sdr_dout),
    .ridx_i   (idx),
    .rvalid_o (st_valid),
    .rtag_o   (st_tag),
    .rdata_o  (st_data)
  );

  // Request/fill FSM with registered client and controller outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_data_q  <= '0;
      rd_ack_q   <= 1'b0;
      sdr_addr_q <= '0;
      sdr_req_q  <= 1'b0;
      pend_q     <= 1'b0;
      off_q      <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
    end else begin
      rd_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hit_go) begin
            rd_data_q <= word_sel(st_data, off);
            rd_ack_q  <= 1'b1;
          end else if (miss_go) begin
            sdr_addr_q <= {rd_addr[AW:3], 2'b00};
            sdr_req_q  <= 1'b1;
            off_q      <= off;
            idx_q      <= idx;
            tag_q      <= tag;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (flush) begin
            pend_q <= 1'b1;
          end
          if (sdr_ready) begin
            rd_data_q <= word_sel(sdr_dout, off_q);
            rd_ack_q  <= rd_req;
            sdr_req_q <= 1'b0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          pend_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_ack   = rd_ack_q;
  assign sdr_addr = sdr_addr_q;
  assign sdr_req  = sdr_req_q;

`ifdef SDRAM_LINE_CACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Saturating hit/miss counters, cleared along with the cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (flush) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_go && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (miss_go && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_line_cache.sv
// tb_sdram_line_cache: random reads against a cache/ROM model.
// Directed cases for misses, conflicts, flush, drop and reset.
`timescale 1ns/1ps
module tb_sdram_line_cache;

  localparam int LINES = 16;
  localparam int AW    = 26;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW:1]   rd_addr = '0;
  logic          rd_req = 1'b0;
  logic [15:0]   rd_data;
  logic          rd_ack;
  logic [AW:1]   sdr_addr;
  logic          sdr_req;
  logic [63:0]   sdr_dout = '0;
  logic          sdr_ready = 1'b0;

  always #5 clk = ~clk;

  sdram_line_cache #(
    .LINES (LINES),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rd_addr   (rd_addr),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_ack    (rd_ack),
    .sdr_addr  (sdr_addr),
    .sdr_req   (sdr_req),
    .sdr_dout  (sdr_dout),
    .sdr_ready (sdr_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: cache contents plus ROM generation.
  bit           m_valid [LINES];
  int unsigned  m_tag   [LINES];
  logic [63:0]  m_data  [LINES];
  int unsigned  gen = 0;
  logic [15:0]  exp_q[$];
  bit           fill_exp = 0;
  logic [AW:1]  exp_line = '0;
  int unsigned  cur_off = 0;
  bit           flush_in_fill = 0;
  bit           abort = 0;
  bit           ctl_busy = 0;
  bit           force_en = 0;
  logic [63:0]  force_data = '0;
  int           lat_min = 2;
  int           lat_max = 6;
  int           n_fills = 0;
  logic [AW:1]  last_sdr_addr = '0;

  function automatic logic [63:0] rom(input int unsigned line,
                                      input int unsigned g);
    logic [63:0] r;
    for (int w = 0; w < 4; w++) begin
      r[w*16 +: 16] = 16'(line * 40503 + w * 4099 + g * 7919 + 1);
    end
    return r;
  endfunction

  function automatic int unsigned idx_of(input int unsigned a);
    return (a / 4) % LINES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned a);
    return a / (4 * LINES);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    gen++;
  endtask

  // Compare process: every acknowledged word and every request cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_ack) begin
        if (exp_q.size() == 0) check("ack_without_request", rd_ack, 1'b0);
        else check("rd_data", rd_data, exp_q.pop_front());
      end
      if (!fill_exp) check("sdr_req_idle", sdr_req, 1'b0);
      if (sdr_req) check("sdr_addr", sdr_addr, exp_line);
    end
  end

  // SDRAM controller model: answers each sdr_req rising edge.
  initial begin : ctl
    logic        prev;
    logic [AW:1] line;
    int          lat;
    int          low_cnt;
    bit          seen_fill;
    logic [63:0] d;
    int unsigned ix;
    prev = 1'b0;
    low_cnt = 0;
    seen_fill = 0;
    forever begin
      @(negedge clk);
      if (sdr_req && !prev) begin
        ctl_busy = 1;
        n_fills++;
        if (seen_fill) check("req_low_gap", low_cnt >= 1, 1'b1);
        line = sdr_addr;
        last_sdr_addr = line;
        lat = $urandom_range(lat_max, lat_min);
        repeat (lat - 1) @(negedge clk);
        d = force_en ? force_data : rom(int'(line), gen);
        sdr_dout = d;
        sdr_ready = 1'b1;
        if (!abort) begin
          if (rd_req) exp_q.push_back(d[cur_off*16 +: 16]);
          if (!flush_in_fill) begin
            ix = idx_of(int'(line));
            m_valid[ix] = 1;
            m_tag[ix] = tag_of(int'(line));
            m_data[ix] = d;
          end
        end
        @(negedge clk);
        sdr_ready = 1'b0;
        sdr_dout = {$urandom, $urandom};
        if (!abort) fill_exp = 0;
        abort = 0;
        flush_in_fill = 0;
        ctl_busy = 0;
        seen_fill = 1;
        low_cnt = sdr_req ? 0 : 1;
      end else if (!sdr_req) begin
        low_cnt++;
      end
      prev = sdr_req;
    end
  end

  // One client read. mode 0 normal, 1 drop rd_req mid-fill,
  // 2 flush mid-fill.
  task automatic do_read(input int unsigned a, input int mode);
    int unsigned ix;
    bit          hit;
    int          cyc;
    int          rise;
    bit          done;
    ix = idx_of(a);
    hit = m_valid[ix] && (m_tag[ix] == tag_of(a));
    cyc = 0;
    rise = -1;
    done = 0;
    rd_addr = AW'(a);
    rd_req = 1'b1;
    cur_off = a % 4;
    if (hit) begin
      exp_q.push_back(m_data[ix][(a % 4)*16 +: 16]);
    end else begin
      fill_exp = 1;
      exp_line = AW'((a / 4) * 4);
    end
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (flush) flush = 1'b0;
      if (!hit && rise < 0 && sdr_req) begin
        rise = cyc;
        if (mode == 1) rd_req = 1'b0;
        if (mode == 2) begin
          flush = 1'b1;
          flush_in_fill = 1;
          model_clear();
        end
      end
      if (rd_ack) done = 1;
      if (mode == 1 && rise >= 0 && cyc > rise && !ctl_busy) done = 1;
    end
    if (mode != 1) check("ack_seen", rd_ack, 1'b1);
    if (hit) check("hit_latency", cyc, 1);
    else check("miss_req_latency", rise, 1);
    rd_req = 1'b0;
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_flush();
    flush = 1'b1;
    model_clear();
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int unsigned a;
    int r;
    int cnt;

    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 16'h0);
    check("reset_rd_ack", rd_ack, 1'b0);
    check("reset_sdr_req", sdr_req, 1'b0);
    check("reset_sdr_addr", sdr_addr, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss with a known line, then a hit on word 3.
    force_en = 1;
    force_data = 64'h4444_3333_2222_1111;
    do_read(32'h10, 0);
    check("cold_sdr_addr", last_sdr_addr, 26'h10);
    check("cold_rd_data", rd_data, 16'h1111);
    force_en = 0;
    base = n_fills;
    do_read(32'h13, 0);
    check("warm_rd_data", rd_data, 16'h4444);
    check("warm_no_fill", n_fills - base, 0);

    // Conflict on index 4.
    base = n_fills;
    do_read(32'h90, 0);
    do_read(32'h10, 0);
    check("conflict_refills", n_fills - base, 2);

    // Four back-to-back hits on the resident line.
    for (int w = 0; w < 4; w++) begin
      rd_addr = AW'(32'h10 + w);
      rd_req = 1'b1;
      exp_q.push_back(m_data[4][w*16 +: 16]);
      @(negedge clk);
      check("b2b_ack", rd_ack, 1'b1);
    end
    rd_req = 1'b0;
    @(negedge clk);

    // Flush during fill, then the same address fills again.
    base = n_fills;
    do_read(32'h200, 2);
    do_read(32'h200, 0);
    check("refill_after_flush", n_fills - base, 2);

    // Client drops request mid-fill; line still installed.
    base = n_fills;
    do_read(32'h302, 1);
    do_read(32'h301, 0);
    check("drop_then_hit", n_fills - base, 1);

    // Flush has priority over a request in IDLE.
    do_read(32'h10, 0);
    rd_addr = AW'(32'h10);
    rd_req = 1'b1;
    flush = 1'b1;
    model_clear();
    @(negedge clk);
    check("flush_prio_ack", rd_ack, 1'b0);
    check("flush_prio_req", sdr_req, 1'b0);
    flush = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    base = n_fills;
    do_read(32'h10, 0);
    check("flush_prio_refill", n_fills - base, 1);

    // Asynchronous reset in the middle of a fill.
    lat_min = 4;
    rd_addr = AW'(32'h40);
    rd_req = 1'b1;
    cur_off = 0;
    fill_exp = 1;
    exp_line = AW'(32'h40);
    cnt = 0;
    while (!sdr_req && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_fill_started", sdr_req, 1'b1);
    @(negedge clk);
    abort = 1;
    fill_exp = 0;
    rd_req = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sdr_req", sdr_req, 1'b0);
    check("rst_mid_rd_ack", rd_ack, 1'b0);
    check("rst_mid_rd_data", rd_data, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (ctl_busy && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("late_ready_done", ctl_busy, 1'b0);
    @(negedge clk);
    lat_min = 2;
    base = n_fills;
    do_read(32'h40, 0);
    check("miss_after_reset", n_fills - base, 1);

    // Randomized traffic over a few tags per index.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(99, 0);
      a = $urandom_range(3, 0) * 64 + $urandom_range(15, 0) * 4
        + $urandom_range(3, 0);
      if ($urandom_range(7, 0) == 0) a = a + ($urandom_range(1023, 1) << 12);
      if (r < 5) idle_flush();
      else if (r < 12) do_read(a, 1);
      else if (r < 16) do_read(a, 2);
      else do_read(a, 0);
    end

    repeat (4) @(negedge clk);
    check("expected_acks_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
